mem_arbiter: RTL and testbench

Two-requester arbiter for the single unified memory port. Shares the memory between the multicycle MIPS core (requester 0) and a second bus master such as a program loader or DMA engine (requester 1). Uses a registered-grant FSM with round-robin priority and a bounded hold time, so neither master can starve the other. Sits between the requesters' memory ports and the memory's `mem_*` interface.

---
 rtl/mem_arbiter.sv | 77 +++++++
 tb/tb_mem_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin memory arbiter with registered grants
// and a bounded hold time so neither master can starve the other.
module mem_arbiter #(
   parameter int N        = 32,
   parameter int MAX_HOLD = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0,
   input  logic         req1,
   input  logic         wr0,
   input  logic         wr1,
   input  logic [N-1:0] addr0,
   input  logic [N-1:0] addr1,
   input  logic [N-1:0] wdata0,
   input  logic [N-1:0] wdata1,
   output logic         gnt0,
   output logic         gnt1,
   output logic         rd_valid0,
   output logic         rd_valid1,
   output logic [N-1:0] rd_data,
   output logic         mem_wr_ena,
   output logic [N-1:0] mem_addr,
   output logic [N-1:0] mem_wr_data,
   input  logic [N-1:0] mem_rd_data
);
   localparam int HW = $clog2(MAX_HOLD) + 1;
   localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD - 1);

   typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

   state_t        state, next;
   logic          last;
   logic [HW-1:0] hold;
   logic          issue0, issue1, at_limit;

   assign gnt0        = state == GRANT0;
   assign gnt1        = state == GRANT1;
   assign issue0      = gnt0 & req0;
   assign issue1      = gnt1 & req1;
   assign at_limit    = hold == HOLD_MAX;
   assign mem_addr    = issue0 ? addr0 : issue1 ? addr1 : '0;
   assign mem_wr_data = issue0 ? wdata0 : issue1 ? wdata1 : '0;
   assign mem_wr_ena  = (issue0 & wr0) | (issue1 & wr1);
   assign rd_data     = mem_rd_data;

   // the hold limit only forces a handover while the other side is waiting
   always_comb begin
      next = state;
      case (state)
         IDLE:    next = (req0 & req1) ? (last ? GRANT0 : GRANT1) : req0 ? GRANT0 : req1 ? GRANT1 : IDLE;
         GRANT0:  next = !req0 ? (req1 ? GRANT1 : IDLE) : (req1 & at_limit) ? GRANT1 : GRANT0;
         GRANT1:  next = !req1 ? (req0 ? GRANT0 : IDLE) : (req0 & at_limit) ? GRANT0 : GRANT1;
         default: next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         last      <= 1'b1;
         hold      <= '0;
         rd_valid0 <= 1'b0;
         rd_valid1 <= 1'b0;
      end else begin
         state     <= next;
         rd_valid0 <= issue0 & ~wr0;
         rd_valid1 <= issue1 & ~wr1;
         if (next != state && next != IDLE) begin
            hold <= '0;
            last <= next == GRANT1;
         end else if ((issue0 | issue1) && !at_limit) begin
            hold <= hold + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table vectors, directed corner sequences and random traffic
// checked against an owner/access-count reference model with a shadow memory.
module tb_mem_arbiter;
   localparam int N  = 32;
   localparam int MH = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          req[2];
   logic          wr[2];
   logic [N-1:0]  addr[2];
   logic [N-1:0]  wdata[2];
   logic          gnt0, gnt1, rd_valid0, rd_valid1, mem_wr_ena;
   logic [N-1:0]  rd_data, mem_addr, mem_wr_data, mem_rd_data;

   mem_arbiter #(.N(N), .MAX_HOLD(MH)) dut (
      .clk(clk), .rst(rst),
      .req0(req[0]), .req1(req[1]), .wr0(wr[0]), .wr1(wr[1]),
      .addr0(addr[0]), .addr1(addr[1]), .wdata0(wdata[0]), .wdata1(wdata[1]),
      .gnt0(gnt0), .gnt1(gnt1), .rd_valid0(rd_valid0), .rd_valid1(rd_valid1),
      .rd_data(rd_data), .mem_wr_ena(mem_wr_ena), .mem_addr(mem_addr),
      .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
   );

   always #5 clk = ~clk;

   function automatic logic [N-1:0] init_val(input int i);
      return (i == 16) ? 32'hDEADBEEF : (32'(i) * 32'h01010101) ^ 32'hA5A50000;
   endfunction

   // memory with one-cycle read latency, preloaded on the first edge
   logic [N-1:0] mem[256];
   logic         loaded = 1'b0;
   always @(posedge clk) begin
      if (!loaded) begin
         for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
         loaded <= 1'b1;
      end else if (mem_wr_ena) begin
         mem[mem_addr[9:2]] <= mem_wr_data;
      end
      mem_rd_data <= mem[mem_addr[9:2]];
   end

   // reference model: who owns the port and how many accesses it has made
   logic [N-1:0] ref_mem[256];
   int           owner, cnt, lastg;
   logic         pv[2];
   logic [N-1:0] pdata;
   int           passed = 0, total = 0;

   task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      else passed++;
   endtask

   task automatic model_reset();
      owner = -1; cnt = 0; lastg = 1; pv = '{1'b0, 1'b0};
   endtask

   task automatic grant(input int n);
      owner = n; cnt = 0; lastg = n;
   endtask

   task automatic model_check(input string tag);
      int   x;
      logic iss;
      x   = owner;
      iss = (x >= 0) ? req[x] : 1'b0;
      chk({tag, " gnt0"}, gnt0, owner == 0);
      chk({tag, " gnt1"}, gnt1, owner == 1);
      chk({tag, " mem_addr"}, mem_addr, iss ? addr[x] : '0);
      chk({tag, " mem_wr_data"}, mem_wr_data, iss ? wdata[x] : '0);
      chk({tag, " mem_wr_ena"}, mem_wr_ena, iss && wr[x]);
      chk({tag, " rd_valid0"}, rd_valid0, pv[0]);
      chk({tag, " rd_valid1"}, rd_valid1, pv[1]);
      if (pv[0] || pv[1]) chk({tag, " rd_data"}, rd_data, pdata);
   endtask

   task automatic model_update();
      int         x, y;
      logic       iss;
      logic [7:0] idx;
      x   = owner;
      iss = (x >= 0) ? req[x] : 1'b0;
      pv  = '{1'b0, 1'b0};
      if (iss) begin
         idx = addr[x][9:2];
         if (wr[x]) ref_mem[idx] = wdata[x];
         else begin
            pv[x] = 1'b1;
            pdata = ref_mem[idx];
         end
      end
      if (x < 0) begin
         if (req[0] && req[1]) grant(1 - lastg);
         else if (req[0]) grant(0);
         else if (req[1]) grant(1);
      end else begin
         y = 1 - x;
         if (!req[x]) begin
            if (req[y]) grant(y);
            else owner = -1;
         end else if (req[y] && cnt >= MH - 1) grant(y);
         else cnt++;
      end
   endtask

   task automatic tick();
      model_update();
      @(negedge clk);
   endtask

   task automatic step(input string tag);
      #1;
      model_check(tag);
      tick();
   endtask

   task automatic drive(input logic r0, r1, w0, w1, input logic [N-1:0] a0, a1, d0, d1);
      req[0] = r0; req[1] = r1; wr[0] = w0; wr[1] = w1;
      addr[0] = a0; addr[1] = a1; wdata[0] = d0; wdata[1] = d1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      drive(0, 0, 0, 0, 32'h40, 32'h100, 0, 32'h12345678);
      repeat (3) @(negedge clk);
      #1;
      chk("reset gnt", {gnt0, gnt1, rd_valid0, rd_valid1, mem_wr_ena}, 0);
      chk("reset mem_addr", mem_addr, 0);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
   endtask

   typedef struct {
      logic r0, r1, w0, w1;
      logic g0, g1, we, rv0;
      logic [N-1:0] ma;
   } vec_t;

   vec_t tv[7];

   initial begin
      tv[0] = '{0, 0, 0, 0,  0, 0, 0, 0, 32'h0};
      tv[1] = '{1, 0, 0, 0,  0, 0, 0, 0, 32'h0};
      tv[2] = '{1, 0, 0, 0,  1, 0, 0, 0, 32'h40};
      tv[3] = '{0, 1, 0, 1,  1, 0, 0, 1, 32'h0};
      tv[4] = '{0, 1, 0, 1,  0, 1, 1, 0, 32'h100};
      tv[5] = '{0, 0, 0, 0,  0, 1, 0, 0, 32'h0};
      tv[6] = '{0, 0, 0, 0,  0, 0, 0, 0, 32'h0};
      for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
      model_reset();
      @(negedge clk);
      do_reset();

      for (int k = 0; k < 10; k++) step("idle");

      // single read, write path and release back to idle
      foreach (tv[i]) begin
         drive(tv[i].r0, tv[i].r1, tv[i].w0, tv[i].w1, 32'h40, 32'h100, 0, 32'h12345678);
         #1;
         chk($sformatf("vec%0d gnt", i), {gnt0, gnt1}, {tv[i].g0, tv[i].g1});
         chk($sformatf("vec%0d wr_ena", i), mem_wr_ena, tv[i].we);
         chk($sformatf("vec%0d rd_valid0", i), rd_valid0, tv[i].rv0);
         chk($sformatf("vec%0d mem_addr", i), mem_addr, tv[i].ma);
         if (tv[i].rv0) chk("vec rd_data", rd_data, 32'hDEADBEEF);
         if (tv[i].we) chk("vec wr_data", mem_wr_data, 32'h12345678);
         model_check($sformatf("vec%0d", i));
         tick();
      end

      // tie from reset: 4 accesses each, alternating, no bubble
      do_reset();
      drive(1, 1, 0, 0, 32'h40, 32'h100, 0, 0);
      for (int k = 0; k < 17; k++) begin
         #1;
         chk($sformatf("tie%0d gnt", k), {gnt0, gnt1},
             (k == 0) ? 2'b00 : (((k - 1) / MH) % 2 == 0) ? 2'b10 : 2'b01);
         model_check("tie");
         tick();
      end

      // early release after 2 accesses
      do_reset();
      drive(1, 0, 0, 0, 32'h44, 32'h104, 0, 0);
      step("rel0");
      req[1] = 1'b1;
      step("rel1");
      step("rel2");
      req[0] = 1'b0;
      #1;
      chk("rel3 gnt0", gnt0, 1'b1);
      chk("rel3 mem_addr", mem_addr, 0);
      model_check("rel3");
      tick();
      #1;
      chk("rel4 gnt1", {gnt0, gnt1}, 2'b01);
      model_check("rel4");
      tick();
      req[1] = 1'b0;
      step("rel5");
      #1;
      chk("rel6 idle", {gnt0, gnt1, mem_wr_ena}, 0);
      chk("rel6 mem_addr", mem_addr, 0);
      model_check("rel6");
      tick();

      // asynchronous reset while a read is in flight
      drive(1, 0, 0, 0, 32'h40, 32'h100, 0, 0);
      step("mid0");
      step("mid1");
      #1;
      model_check("mid2");
      #2 rst = 1'b0;
      #1;
      chk("mid async gnt0", gnt0, 1'b0);
      chk("mid async rd_valid0", rd_valid0, 1'b0);
      chk("mid async mem", {mem_wr_ena, mem_addr}, 0);
      model_reset();
      req[0] = 1'b0;
      @(negedge clk);
      #1;
      chk("mid discard rd_valid0", rd_valid0, 1'b0);
      rst = 1'b1;
      drive(1, 1, 0, 0, 32'h40, 32'h100, 0, 0);
      step("mid tie0");
      #1;
      chk("mid tie gnt", {gnt0, gnt1}, 2'b10);
      model_check("mid tie1");
      tick();

      // random traffic; addr/wr/wdata change only when legal
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < 2; i++) begin
            if ($urandom_range(0, 3) == 0) req[i] = ~req[i];
            if (!req[i] || owner == i) begin
               wr[i]    = $urandom_range(0, 3) == 0;
               addr[i]  = {22'd0, 8'($urandom), 2'b00};
               wdata[i] = $urandom;
            end
         end
         step("rand");
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
